// File: rtl/src_mac_axil_pkg.sv
// Shared constants, types and helpers for the source-MAC AXI4-Lite register block.
package src_mac_axil_pkg;

    typedef logic [47:0] mac_t;

    localparam logic [3:0] ADDR_MAC_LO = 4'h0;
    localparam logic [3:0] ADDR_MAC_HI = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int unsigned COMMIT_BIT = 0;
    localparam int unsigned ENABLE_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Registers are word aligned; the low two byte-address bits never select anything.
    function automatic logic [3:0] word_addr(input logic [1:0] idx);
        return {idx, 2'b00};
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/src_mac_axil_chan_buf.sv
// One-entry valid/data holding buffer for an AXI4-Lite request channel; ready = !full.
module src_mac_axil_chan_buf #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic [Width-1:0] data_o
);

    logic             full_q;
    logic [Width-1:0] data_q;

    // Held low during reset so no handshake can complete while the block is being cleared.
    assign ready_o = !full_q && !rst_i;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (valid_i && ready_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/src_mac_axil_regs.sv
// AXI4-Lite register file for the TX framer source MAC: shadow words, control/status,
// and an atomically committed 48-bit active address.
module src_mac_axil_regs
    import src_mac_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [47:0] DEFAULT_MAC        = 48'h000A35000001
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [47:0]                     mac_addr,
    output logic                            mac_valid,
    output logic                            mac_update
);

    localparam int unsigned WBufWidth = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH / 8;

    logic                            aw_full, w_full, do_write, ar_hs;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [WBufWidth-1:0]            w_buf_data;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;

    logic [31:0] mac_lo_q, mac_lo_d;
    logic [15:0] mac_hi_q, mac_hi_d;
    logic        enable_q, enable_d;
    logic        commit, wr_err;
    logic [15:0] commit_cnt_q;
    mac_t        mac_addr_q;
    logic        mac_update_q;
    logic        bvalid_q, rvalid_q;
    logic [1:0]  bresp_q;
    logic [31:0] rdata_q, rd_data;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR, aw_addr};

    src_mac_axil_chan_buf #(
        .Width (C_S_AXI_ADDR_WIDTH)
    ) u_aw_buf (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (S_AXI_AWVALID),
        .ready_o (S_AXI_AWREADY),
        .data_i  (S_AXI_AWADDR),
        .pop_i   (do_write),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    src_mac_axil_chan_buf #(
        .Width (WBufWidth)
    ) u_w_buf (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .valid_i (S_AXI_WVALID),
        .ready_o (S_AXI_WREADY),
        .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .pop_i   (do_write),
        .full_o  (w_full),
        .data_o  (w_buf_data)
    );

    assign {w_strb, w_data} = w_buf_data;
    assign do_write         = aw_full && w_full && !bvalid_q;
    assign ar_hs            = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        mac_lo_d = mac_lo_q;
        mac_hi_d = mac_hi_q;
        enable_d = enable_q;
        commit   = 1'b0;
        wr_err   = 1'b0;
        if (do_write) begin
            case (word_addr(aw_addr[3:2]))
                ADDR_MAC_LO: mac_lo_d = merge_strb(mac_lo_q, w_data, w_strb);
                ADDR_MAC_HI: begin
                    if (w_strb[0]) mac_hi_d[7:0]  = w_data[7:0];
                    if (w_strb[1]) mac_hi_d[15:8] = w_data[15:8];
                end
                ADDR_CTRL: begin
                    if (w_strb[0]) begin
                        enable_d = w_data[ENABLE_BIT];
                        commit   = w_data[COMMIT_BIT];
                    end
                end
                default: wr_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_data = 32'h0;
        case (word_addr(S_AXI_ARADDR[3:2]))
            ADDR_MAC_LO: rd_data = mac_lo_q;
            ADDR_MAC_HI: rd_data = {16'h0, mac_hi_q};
            ADDR_CTRL:   rd_data = {30'h0, enable_q, 1'b0};
            ADDR_STATUS: rd_data = {15'h0, enable_q, commit_cnt_q};
            default:     rd_data = 32'h0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mac_lo_q     <= DEFAULT_MAC[31:0];
            mac_hi_q     <= DEFAULT_MAC[47:32];
            enable_q     <= 1'b0;
            commit_cnt_q <= 16'h0;
            mac_addr_q   <= DEFAULT_MAC;
            mac_update_q <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'h0;
        end else begin
            mac_lo_q     <= mac_lo_d;
            mac_hi_q     <= mac_hi_d;
            enable_q     <= enable_d;
            mac_update_q <= commit;
            // Commit takes the shadow as it stood before this edge's write.
            if (commit) begin
                mac_addr_q   <= {mac_hi_q, mac_lo_q};
                commit_cnt_q <= commit_cnt_q + 16'd1;
            end
            if (do_write) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_ARREADY = !rvalid_q && !ARESET;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign mac_addr      = mac_addr_q;
    assign mac_valid     = enable_q;
    assign mac_update    = mac_update_q;

endmodule

// File: tb/tb_src_mac_axil_regs.sv
// Directed bench for src_mac_axil_regs: register map, strobes, commit, channel ordering,
// backpressure, counter wrap and mid-transaction reset.
module tb_src_mac_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b1;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b1;
    logic [47:0] mac_addr;
    logic        mac_valid;
    logic        mac_update;

    int checks = 0;
    int failures = 0;
    int upd_cnt = 0;

    src_mac_axil_regs dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .mac_addr      (mac_addr),
        .mac_valid     (mac_valid),
        .mac_update    (mac_update)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        if (mac_update === 1'b1) upd_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge after the B handshake.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, hs_aw, hs_w;
        int n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            if (hs_aw) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
            if (hs_w)  begin w_done = 1'b1;  S_AXI_WVALID = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check($sformatf("wr_bvalid_%h", addr), {63'h0, S_AXI_BVALID}, 64'h1);
        resp = S_AXI_BRESP;
        @(negedge ACLK);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        n = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (S_AXI_ARREADY !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (S_AXI_RVALID !== 1'b1 && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check($sformatf("rd_rvalid_%h", addr), {63'h0, S_AXI_RVALID}, 64'h1);
        data = S_AXI_RDATA;
        @(negedge ACLK);
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, {32'h0, d}, {32'h0, exp});
    endtask

    initial begin
        logic [1:0] resp;

        // Reset state, sampled while reset is held.
        repeat (3) @(negedge ACLK);
        check("rst_ready", {61'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 64'h0);
        check("rst_valid", {62'h0, S_AXI_BVALID, S_AXI_RVALID}, 64'h0);
        check("rst_resp", {60'h0, S_AXI_BRESP, S_AXI_RRESP}, 64'h0);
        check("rst_rdata", {32'h0, S_AXI_RDATA}, 64'h0);
        check("rst_mac", {16'h0, mac_addr}, 64'h000A35000001);
        check("rst_mac_flags", {62'h0, mac_valid, mac_update}, 64'h0);
        ARESET = 1'b0;
        @(negedge ACLK);

        read_check("def_lo", 4'h0, 32'h35000001);
        read_check("def_hi", 4'h4, 32'h0000000A);
        read_check("def_ctrl", 4'h8, 32'h0);
        read_check("def_status", 4'hC, 32'h0);

        // Basic map, commit, and SLVERR on STATUS.
        axi_write(4'h0, 32'h00000001, 4'hF, resp);
        check("wr_lo_resp", {62'h0, resp}, 64'h0);
        axi_write(4'h4, 32'h00000002, 4'hF, resp);
        check("wr_hi_resp", {62'h0, resp}, 64'h0);
        axi_write(4'h8, 32'h00000003, 4'hF, resp);
        check("wr_ctrl_resp", {62'h0, resp}, 64'h0);
        axi_write(4'hC, 32'h00000004, 4'hF, resp);
        check("wr_status_resp", {62'h0, resp}, 64'h2);
        read_check("rb_lo", 4'h0, 32'h00000001);
        read_check("rb_hi", 4'h4, 32'h00000002);
        read_check("rb_ctrl", 4'h8, 32'h00000002);
        read_check("rb_status", 4'hC, 32'h00010001);
        check("commit_mac", {16'h0, mac_addr}, 64'h000200000001);
        check("commit_valid", {63'h0, mac_valid}, 64'h1);
        check("commit_pulses", upd_cnt, 64'd1);

        // Byte strobes; active MAC only moves on commit.
        axi_write(4'h0, 32'hAABBCCDD, 4'b0101, resp);
        read_check("strb_lo", 4'h0, 32'h00BB00DD);
        check("strb_mac_hold", {16'h0, mac_addr}, 64'h000200000001);
        axi_write(4'h8, 32'h00000003, 4'hF, resp);
        check("strb_mac_commit", {16'h0, mac_addr}, 64'h000200BB00DD);
        check("strb_pulses", upd_cnt, 64'd2);
        axi_write(4'h0, 32'h12345678, 4'b0000, resp);
        check("strb0_resp", {62'h0, resp}, 64'h0);
        read_check("strb0_lo", 4'h0, 32'h00BB00DD);

        // W leads AW by three cycles; upper half of MAC_HI is dropped.
        S_AXI_WDATA = 32'hFFFF1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        check("wfirst_wready", {63'h0, S_AXI_WREADY}, 64'h0);
        repeat (2) @(negedge ACLK);
        check("wfirst_no_b", {63'h0, S_AXI_BVALID}, 64'h0);
        S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        check("wfirst_b_lat0", {63'h0, S_AXI_BVALID}, 64'h0);
        @(negedge ACLK);
        check("wfirst_b_lat1", {61'h0, S_AXI_BVALID, S_AXI_BRESP}, 64'h4);
        @(negedge ACLK);
        check("wfirst_b_done", {61'h0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 64'h3);
        read_check("wfirst_hi", 4'h4, 32'h00001234);

        // AW leads W by three cycles.
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
        check("awfirst_awready", {63'h0, S_AXI_AWREADY}, 64'h0);
        repeat (2) @(negedge ACLK);
        check("awfirst_no_b", {63'h0, S_AXI_BVALID}, 64'h0);
        S_AXI_WDATA = 32'h11223344; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        check("awfirst_b_lat0", {63'h0, S_AXI_BVALID}, 64'h0);
        @(negedge ACLK);
        check("awfirst_b_lat1", {61'h0, S_AXI_BVALID, S_AXI_BRESP}, 64'h4);
        @(negedge ACLK);
        check("awfirst_b_done", {63'h0, S_AXI_BVALID}, 64'h0);
        read_check("awfirst_lo", 4'h0, 32'h11223344);

        // Backpressure on B and R with a second write queued behind the first.
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h55667788; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h00009999;
        @(negedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold_%0d", i),
                  {25'h0, S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID, S_AXI_RRESP,
                   S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RDATA},
                  {25'h0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h11223344});
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        check("stall_release", {61'h0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_ARREADY}, 64'h1);
        @(negedge ACLK);
        check("stall_second_b", {63'h0, S_AXI_BVALID}, 64'h1);
        @(negedge ACLK);
        read_check("stall_lo", 4'h0, 32'h55667788);
        read_check("stall_hi", 4'h4, 32'h00009999);

        // Counter wrap.
        force dut.commit_cnt_q = 16'hFFFF;
        @(negedge ACLK);
        release dut.commit_cnt_q;
        read_check("wrap_pre", 4'hC, 32'h0001FFFF);
        axi_write(4'h8, 32'h00000003, 4'hF, resp);
        read_check("wrap_post", 4'hC, 32'h00010000);
        check("wrap_mac", {16'h0, mac_addr}, 64'h999955667788);
        check("wrap_pulses", upd_cnt, 64'd3);

        // Reset with a write buffered but not yet executed.
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("midrst_no_b", {63'h0, S_AXI_BVALID}, 64'h0);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
        check("midrst_still_no_b", {63'h0, S_AXI_BVALID}, 64'h0);
        read_check("midrst_lo", 4'h0, 32'h35000001);
        read_check("midrst_hi", 4'h4, 32'h0000000A);
        read_check("midrst_ctrl", 4'h8, 32'h0);
        read_check("midrst_status", 4'hC, 32'h0);
        check("midrst_mac", {16'h0, mac_addr}, 64'h000A35000001);
        check("midrst_valid", {63'h0, mac_valid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/src_mac_axil_regs.md
Name: src_mac_axil_regs

Overview:
- AXI4-Lite responder (slave) register file holding the Ethernet source MAC address used by the TX framer.
- Exposes four 32-bit registers to the PS/VIP master: shadow MAC low and high words, a control register, and a status register.
- On a commit, the shadow MAC is copied atomically to a 48-bit active output so the datapath never sees a half-written address.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 registers.
- DEFAULT_MAC, 48'h000A35000001, reset value of both the shadow and the active MAC.

Ports:
- ACLK in 1: the only clock.
- ARESET in 1: synchronous, active-high reset.
- S_AXI_AWADDR in 4: write address. S_AXI_AWPROT in 3: ignored. S_AXI_AWVALID in 1. S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32. S_AXI_WSTRB in 4. S_AXI_WVALID in 1. S_AXI_WREADY out 1.
- S_AXI_BRESP out 2. S_AXI_BVALID out 1. S_AXI_BREADY in 1.
- S_AXI_ARADDR in 4. S_AXI_ARPROT in 3: ignored. S_AXI_ARVALID in 1. S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32. S_AXI_RRESP out 2. S_AXI_RVALID out 1. S_AXI_RREADY in 1.
- mac_addr out 48: active MAC.
- mac_valid out 1: equals CTRL.ENABLE.
- mac_update out 1: one-cycle pulse on each commit.

Behaviour:
- Register map, decoded on addr[3:2]:
  - 0x0 MAC_LO: RW [31:0].
  - 0x4 MAC_HI: RW [15:0]; bits [31:16] read 0 and writes to them are dropped.
  - 0x8 CTRL: bit0 COMMIT is write-1-to-act and reads 0; bit1 ENABLE is RW; other bits read 0.
  - 0xC STATUS: RO; [15:0] commit_cnt, [16] ENABLE, [31:17] read 0.
- Reset (ARESET high at an ACLK edge):
  - All READY/VALID outputs 0; BRESP and RRESP 00; RDATA 0.
  - Shadow and mac_addr = DEFAULT_MAC; ENABLE 0; commit_cnt 0; mac_update 0; both channel buffers emptied.
  - Reset mid-transaction drops the transaction silently; no BVALID or RVALID follows.
- Write path:
  - AW and W each have a one-entry buffer. AWREADY = AW buffer empty; WREADY = W buffer empty. Either may arrive first or both in the same cycle.
  - At the first edge where both buffers are full and BVALID = 0: perform the write, set BVALID, clear both buffers. Minimum latency is 1 cycle from the later handshake edge to BVALID.
  - Byte lanes are honoured via WSTRB; WSTRB = 0 performs no update but still returns a response.
  - BVALID holds until BREADY. No new write executes while BVALID = 1; the buffers may still fill.
  - BRESP: OKAY (00) for 0x0/0x4/0x8; SLVERR (10) for 0xC, with no state change.
- Commit: a CTRL write with WSTRB[0] = 1 and WDATA[0] = 1 does the following on the same edge:
  - mac_addr <= {MAC_HI[15:0], MAC_LO}, using shadow values from before this write.
  - mac_update = 1 for exactly that cycle.
  - commit_cnt increments, wrapping 0xFFFF -> 0x0000.
  - The ENABLE update (WDATA[1], lane 0) lands on the same edge.
- Read path:
  - ARREADY = !RVALID. On the AR handshake, RDATA/RRESP are registered and RVALID = 1 on the next edge.
  - RVALID holds with RDATA stable until RREADY; RRESP is always OKAY.
  - A read of a register written on the same edge returns the pre-write value.
- Read and write channels are fully independent; simultaneous activity is legal.
- The block never asserts READY combinationally from VALID.

Decomposition:
- Package src_mac_axil_pkg:
  - Register offsets ADDR_MAC_LO/HI/CTRL/STATUS.
  - CTRL bit indices COMMIT_BIT = 0, ENABLE_BIT = 1.
  - Response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - typedef mac_t = logic [47:0].
- One sub-module, src_mac_axil_chan_buf: a one-entry valid/data holding buffer with ready = !full, instantiated twice (AW: 4-bit address; W: 36-bit data+strobe).

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> 0x35000001, 0x0000000A, 0x0, 0x0; mac_addr = 48'h000A35000001; mac_valid = 0.
- Write 0x0 = 0x00000001, 0x4 = 0x00000002, 0x8 = 0x00000003, 0xC = 0x00000004:
  - First three return BRESP OKAY; the 0xC write returns SLVERR.
  - Readback gives 0x1, 0x2, 0x2, 0x00010001.
  - mac_addr = 48'h000200000001, mac_valid = 1, one mac_update pulse.
- Write 0x0 = 0xAABBCCDD with WSTRB = 4'b0101 over prior 0x00000001 -> readback 0x00BB00DD; mac_addr unchanged until a CTRL write of 0x3.
- W presented 3 cycles before AW, and separately AW 3 cycles before W -> each accepted once; a single BVALID 1 cycle after the later handshake; the register updates correctly.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stay stable, AWREADY/WREADY drop once the buffers refill, ARREADY stays 0; all resume on ready.
- Preload commit_cnt to 0xFFFF via 65535 commits (or force), commit once more -> STATUS[15:0] = 0x0000. Assert ARESET mid-write -> no BVALID; all registers back to defaults.
